burst_write_ptr_blk: RTL
========================

Name: burst_write_ptr_blk

Overview:
Write-side pointer controller for the async FIFO. It accepts up to p_max_wr entries per clk cycle and computes free-slot count, full and programmable almost-full from a multi-stage-synchronized read pointer. It publishes a CDC-safe Gray write pointer that trails the true binary pointer by exactly one step per cycle. It sits in the write clock domain, beside the storage array, and pairs with the read-side pointer block.

Parameters:
p_num_entries, 16, FIFO depth; power of two, >= 4
p_ptr_width, $clog2(p_num_entries)+1, pointer width incl. wrap bit
p_max_wr, 4, max entries accepted per cycle; 1..p_num_entries
p_cnt_width, $clog2(p_max_wr+1), width of w_cnt
p_sync_stages, 2, read-pointer synchronizer depth; >= 2

Ports:
clk  in  1  write-domain clock
reset  in  1  asynchronous, active-high reset; deassertion already synchronized to clk upstream
w_req  in  1  write request this cycle
w_cnt  in  p_cnt_width  number of entries requested
w_ack  out  1  request accepted (all-or-nothing)
b_write_ptr  out  p_ptr_width  true binary write pointer; storage base address for accepted entries
g_write_ptr_pub  out  p_ptr_width  registered Gray pointer to read domain
g_read_ptr_async  in  p_ptr_width  Gray read pointer from read domain
afull_thresh  in  p_ptr_width  almost_full asserts when free_cnt <= this value
free_cnt  out  p_ptr_width  free slots, conservative
full  out  1  free_cnt == 0
almost_full  out  1  free_cnt <= afull_thresh
err  out  1  sticky illegal-request flag
err_clr  in  1  clears err

Behaviour:
- Reset (async, immediate): b_write_ptr=0, internal published binary b_pub=0, g_write_ptr_pub=0, all sync stages=0, err=0. Resulting outputs: free_cnt=p_num_entries, full=0, w_ack=0.
- Sync: g_read_ptr_async passes through a p_sync_stages flop chain, then Gray-to-binary conversion gives b_rd_sync. An input change affects free_cnt after p_sync_stages edges.
- used = (b_write_ptr - b_rd_sync) mod 2^p_ptr_width. free_cnt = p_num_entries - used. All comb from registers only, with no input-to-output path.
- legal = (w_cnt != 0) && (w_cnt <= p_max_wr).
- w_ack = w_req && legal && (w_cnt <= free_cnt). Comb, same cycle.
- On w_ack: b_write_ptr <= b_write_ptr + w_cnt (mod 2^p_ptr_width). No partial acceptance.
- Rejected request: no state change. Requester retries or changes w_cnt.
- w_req && !legal: err <= 1, no ack. err holds until err_clr.
- Same-cycle err_clr and an illegal request: set wins.
- Publish stepping: each cycle with b_pub != b_write_ptr, b_pub <= b_pub+1. g_write_ptr_pub <= bin2gray(next b_pub), so it changes at most one bit per cycle.
- Publish lag: lag = b_write_ptr - b_pub, always <= p_num_entries. The read side therefore never observes data that is not yet published.
- Wrap: all pointer arithmetic is modulo 2^p_ptr_width. The MSB toggles each pass; full is identified via the count, not bit compare.
- free_cnt uses the stale synced read pointer, so it under-reports and never over-reports.
- A write accepted in cycle N appears in free_cnt at cycle N+1.
- A reset mid-burst discards the publish lag; the pointers restart at 0.

Decomposition:
- Package async_fifo_pkg:
  - functions bin2gray and gray2bin, parametrised by width via a let or automatic function
  - no typedefs beyond a ptr width localparam helper
- One sub-module async_fifo_gray_sync: an N-stage vector synchronizer with async reset. The read-side successor reuses it.
- The rest stays flat in burst_write_ptr_blk.

Test Plan:
All scenarios use p_num_entries=8, p_max_wr=4, p_sync_stages=2, with g_read_ptr_async held at 0 unless stated.
1. Reset: assert reset mid-cycle -> all pointers 0, free_cnt=8, full=0, almost_full=0 with afull_thresh=0, err=0, immediately without waiting for a clk edge.
2. Burst: w_req=1, w_cnt=3 -> w_ack=1. Next cycle b_write_ptr=3, free_cnt=5. g_write_ptr_pub goes 0001, 0011, 0010 on the next three edges, then holds.
3. Reject: at b_write_ptr=6, w_cnt=3 -> w_ack=0, pointer stays 6. w_cnt=2 -> w_ack=1, b_write_ptr=8 (1000), full=1, free_cnt=0.
4. Wrap: from full at ptr 8, drive g_read_ptr_async=1100 (bin 8) -> free_cnt=8 two edges later. Write 4 -> b_write_ptr=12. Drive read ptr to bin 12, then write 4 -> b_write_ptr=0 (wrap).
5. Almost-full: afull_thresh=2, write 6 -> almost_full=1, full=0. Drive read to bin 1 -> almost_full=0 after two edges (free=3).
6. Illegal: w_cnt=0 with w_req -> err=1, no ack. w_cnt=5 -> err stays 1. err_clr=1 -> err=0. Illegal request plus err_clr in the same cycle -> err=1.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO pointer blocks.
// Gray conversions work on a 32-bit container; callers zero-extend and then truncate to their own width.
package async_fifo_pkg;

  localparam int c_max_ptr_width = 32;

  function automatic int ptr_width(input int num_entries);
    return $clog2(num_entries) + 1;
  endfunction

  function automatic logic [c_max_ptr_width-1:0] bin2gray(input logic [c_max_ptr_width-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Upper bits are zero for narrower pointers, so the prefix XOR is width-independent.
  function automatic logic [c_max_ptr_width-1:0] gray2bin(input logic [c_max_ptr_width-1:0] gray);
    logic [c_max_ptr_width-1:0] bin;
    bin[c_max_ptr_width-1] = gray[c_max_ptr_width-1];
    for (int i = c_max_ptr_width - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_gray_sync.sv
// N-stage vector synchronizer for a Gray-coded pointer crossing into this clock domain.
// Async reset clears every stage.
module async_fifo_gray_sync #(
  parameter int p_width  = 4,
  parameter int p_stages = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_width-1:0] d,
  output logic [p_width-1:0] q
);

  logic [p_width-1:0] stage_q [p_stages];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_stages; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < p_stages; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[p_stages-1];

endmodule

// File: rtl/burst_write_ptr_blk.sv
// Write-side pointer controller for the async FIFO: burst acceptance, conservative free count,
// and a published Gray pointer that advances at most one step per clock.
module burst_write_ptr_blk
  import async_fifo_pkg::*;
#(
  parameter int p_num_entries = 16,
  parameter int p_ptr_width   = ptr_width(p_num_entries),
  parameter int p_max_wr      = 4,
  parameter int p_cnt_width   = $clog2(p_max_wr + 1),
  parameter int p_sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w_req,
  input  logic [p_cnt_width-1:0] w_cnt,
  output logic                   w_ack,
  output logic [p_ptr_width-1:0] b_write_ptr,
  output logic [p_ptr_width-1:0] g_write_ptr_pub,
  input  logic [p_ptr_width-1:0] g_read_ptr_async,
  input  logic [p_ptr_width-1:0] afull_thresh,
  output logic [p_ptr_width-1:0] free_cnt,
  output logic                   full,
  output logic                   almost_full,
  output logic                   err,
  input  logic                   err_clr
);

  localparam logic [p_ptr_width-1:0] c_depth   = p_ptr_width'(p_num_entries);
  localparam logic [p_cnt_width-1:0] c_max_cnt = p_cnt_width'(p_max_wr);

  logic [p_ptr_width-1:0] g_rd_sync;
  logic [p_ptr_width-1:0] b_rd_sync;
  logic [p_ptr_width-1:0] used_cnt;
  logic [p_ptr_width-1:0] b_pub;
  logic [p_ptr_width-1:0] b_pub_nxt;
  logic [p_ptr_width-1:0] w_cnt_ext;
  logic                   legal;

  async_fifo_gray_sync #(
    .p_width  (p_ptr_width),
    .p_stages (p_sync_stages)
  ) u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (g_read_ptr_async),
    .q     (g_rd_sync)
  );

  assign b_rd_sync = p_ptr_width'(gray2bin(32'(g_rd_sync)));

  // Stale read pointer only ever overstates occupancy, so free_cnt errs low.
  assign used_cnt    = b_write_ptr - b_rd_sync;
  assign free_cnt    = c_depth - used_cnt;
  assign full        = (free_cnt == '0);
  assign almost_full = (free_cnt <= afull_thresh);

  assign w_cnt_ext = p_ptr_width'(w_cnt);
  assign legal     = (w_cnt != '0) && (w_cnt <= c_max_cnt);
  assign w_ack     = w_req && legal && (w_cnt_ext <= free_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_write_ptr <= '0;
    end else if (w_ack) begin
      b_write_ptr <= b_write_ptr + w_cnt_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (w_req && !legal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Single-step publishing keeps the Gray pointer to one bit change per clock.
  assign b_pub_nxt = (b_pub != b_write_ptr) ? b_pub + 1'b1 : b_pub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_pub           <= '0;
      g_write_ptr_pub <= '0;
    end else begin
      b_pub           <= b_pub_nxt;
      g_write_ptr_pub <= p_ptr_width'(bin2gray(32'(b_pub_nxt)));
    end
  end

endmodule
